// File: rtl/pc_ras.sv
`default_nettype none
// ============================================================================
// pc_ras : program counter with a return-address stack (call/ret) and flags
// Rev 1.0
// ============================================================================
module pc_ras #(
  parameter int W       = 16,
  parameter int DEPTH   = 8,
  parameter int STEP    = 1,
  parameter int RST_VEC = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ld,
  input  logic                     inc,
  input  logic                     br,
  input  logic                     call,
  input  logic                     ret,
  input  logic                     flush,
  input  logic                     clr_err,
  input  logic [W-1:0]             target,
  input  logic [W-1:0]             br_off,
  output logic [W-1:0]             pc,
  output logic [W-1:0]             pc_next,
  output logic [$clog2(DEPTH):0]   sp,
  output logic                     full,
  output logic                     empty,
  output logic                     err
);

  localparam int c_AW  = $clog2(DEPTH);
  localparam int c_SPW = c_AW + 1;

  logic [W-1:0]     r_pc;
  logic [W-1:0]     r_stack [DEPTH];
  logic [c_SPW-1:0] r_sp;
  logic             r_err;

  logic [W-1:0]     w_pc_sel;
  logic [W-1:0]     w_pc_inc;
  logic [W-1:0]     w_top;
  logic [c_SPW-1:0] w_sp_nxt;
  logic [c_AW-1:0]  w_push_idx;
  logic [c_AW-1:0]  w_top_idx;
  logic             w_full;
  logic             w_empty;
  logic             w_pop;
  logic             w_push;
  logic             w_ovf;
  logic             w_unf;

  assign w_full     = (r_sp == c_SPW'(DEPTH));
  assign w_empty    = (r_sp == '0);
  assign w_pc_inc   = r_pc + W'(STEP);
  assign w_push_idx = r_sp[c_AW-1:0];
  assign w_top_idx  = w_push_idx - c_AW'(1);
  assign w_top      = r_stack[w_top_idx];

  // ret outranks call, so a call only counts as a push/overflow when ret is low
  always_comb begin
    w_pop    = ret & ~w_empty;
    w_unf    = ret & w_empty;
    w_push   = ~ret & call & ~w_full & ~flush;
    w_ovf    = ~ret & call & w_full;
    w_pc_sel = r_pc;
    w_sp_nxt = r_sp;

    if (ret) begin
      if (w_pop) w_pc_sel = w_top;
    end else if (call) begin
      w_pc_sel = target;
    end else if (ld) begin
      w_pc_sel = target;
    end else if (br) begin
      w_pc_sel = r_pc + br_off;
    end else if (inc) begin
      w_pc_sel = w_pc_inc;
    end

    if (flush)       w_sp_nxt = '0;
    else if (w_pop)  w_sp_nxt = r_sp - c_SPW'(1);
    else if (w_push) w_sp_nxt = r_sp + c_SPW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc  <= W'(RST_VEC);
      r_sp  <= '0;
      r_err <= 1'b0;
    end else begin
      r_pc <= w_pc_sel;
      r_sp <= w_sp_nxt;
      if (w_ovf | w_unf) r_err <= 1'b1;
      else if (clr_err)  r_err <= 1'b0;
    end
  end

  // Stack storage is deliberately not reset; entries at or above sp are dead.
  always_ff @(posedge clk) begin
    if (w_push && !rst) r_stack[w_push_idx] <= w_pc_inc;
  end

  assign pc      = r_pc;
  assign pc_next = rst ? W'(RST_VEC) : w_pc_sel;
  assign sp      = r_sp;
  assign full    = w_full;
  assign empty   = w_empty;
  assign err     = r_err;

endmodule
`default_nettype wire

// File: doc/pc_ras.md
PC_RAS -- requirements
Module: pc_ras

Interface
REQ-001 Parameter W, default 16, program counter and address width in bits.
REQ-002 Parameter DEPTH, default 8, number of return-address stack entries (a power of two, at least 2).
REQ-003 Parameter STEP, default 1, the increment amount added by inc and by call.
REQ-004 Parameter RST_VEC, default 0, the value pc takes on reset.
REQ-005 clk  in  1  single clock; all state updates on the rising edge.
REQ-006 rst  in  1  asynchronous, active-high reset.
REQ-007 ld  in  1  load pc from target.
REQ-008 inc  in  1  advance pc by STEP.
REQ-009 br  in  1  relative branch: pc plus sign-extended br_off.
REQ-010 call  in  1  push pc+STEP onto the stack and jump to target.
REQ-011 ret  in  1  pop the stack top into pc.
REQ-012 flush  in  1  empty the stack; pc is unaffected.
REQ-013 clr_err  in  1  clear the sticky err flag.
REQ-014 target  in  W  absolute address used by ld and call.
REQ-015 br_off  in  W  two's-complement branch offset.
REQ-016 pc  out  W  registered current program counter.
REQ-017 pc_next  out  W  combinational bypass of the value pc takes at the next edge.
REQ-018 sp  out  clog2(DEPTH)+1  registered stack occupancy, range 0..DEPTH.
REQ-019 full, empty  out  1 each  combinational: full = (sp==DEPTH), empty = (sp==0).
REQ-020 err  out  1  sticky flag: stack overflow or underflow occurred.

Function
REQ-021 Operation priority, highest first: ret > call > ld > br > inc > hold; only the winning operation takes effect in a cycle.
REQ-022 Hold: with no control input asserted, pc and the stack are unchanged.
REQ-023 inc: pc <= (pc + STEP) mod 2^W.
REQ-024 br: pc <= (pc + br_off) mod 2^W, with br_off treated as signed.
REQ-025 ld: pc <= target.
REQ-026 call, not full: stack[sp] <= (pc + STEP) mod 2^W, sp <= sp+1, pc <= target.
REQ-027 call, full: pc <= target, the push is discarded, sp is unchanged, and err <= 1.
REQ-028 ret, not empty: pc <= stack[sp-1], sp <= sp-1.
REQ-029 ret, empty: pc holds, sp stays 0, and err <= 1.
REQ-030 flush: sp <= 0 in the same cycle as any pc operation; if ret is also asserted, the pop is applied to pc first, then sp <= 0.
REQ-031 flush with call: the call's push is discarded and sp <= 0; pc <= target.
REQ-032 clr_err: err <= 0, unless a new overflow or underflow occurs in the same cycle, in which case the set wins.
REQ-033 pc_next equals the pc value selected by REQ-021..REQ-029 in the current cycle; it equals pc when holding.
REQ-034 Latency: every operation updates pc one edge after the request; pc_next reflects the request with zero cycles of latency.
REQ-035 Stack entries above sp are don't-care, and reading them is never observable at the outputs.

Reset
REQ-036 rst asserted: immediately, without waiting for clk, pc = RST_VEC, sp = 0, and err = 0; stack contents are not cleared.
REQ-037 rst asserted mid-operation overrides every control input; the first edge after rst is released performs the requested operation normally.
REQ-038 During rst, pc_next = RST_VEC.

Verification
REQ-039 With the default parameters, reset, then assert inc for 3 cycles -> pc = 0,1,2,3; with ld and target = 16'hFFFF, then inc -> pc = 16'hFFFF, then 16'h0000 (wrap).
REQ-040 With pc = 16'h0010, br with br_off = 16'hFFF8 -> pc = 16'h0008; br with br_off = 16'h0004 -> pc = 16'h000C.
REQ-041 Nested calls: at pc = 5, call with target = 16'h0100, then call with target = 16'h0200 -> sp = 2; ret -> pc = 16'h0101 and sp = 1; ret -> pc = 6 and sp = 0 with empty = 1.
REQ-042 Overflow and underflow: perform DEPTH+1 calls -> on the final call full = 1, err = 1, and pc = target; clr_err -> err = 0; ret on an empty stack -> pc holds and err = 1.
REQ-043 Simultaneous events: assert ret, call, ld and inc together with a non-empty stack -> pop only, and pc_next equals the top entry in the same cycle; assert flush with call -> sp = 0 and pc = target.
REQ-044 Asynchronous reset: assert rst between clock edges with pc = 16'h1234 -> pc = 0 and err = 0 before the next edge; release rst with inc asserted -> pc = 1 at the next edge.
